// File: rtl/tf_rd_sched.sv
// Twiddle-factor ROM read sequencer: walks every FFT stage, one address per beat,
// and delays a valid/stage/last tag by the ROM latency so tags line up with rdata.
module tf_rd_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_STAGES = 3,
  parameter int LATENCY    = 1,
  parameter int GAP_CYCLES = 0,
  localparam int SW = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  inverse,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  tf_valid,
  output logic [SW-1:0]         tf_stage,
  output logic                  tf_last_beat,
  output logic                  tf_last,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = NUM_STAGES - 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [BW-1:0] LB = '1;
  localparam logic [SW-1:0] LS = SW'(NUM_STAGES - 1);
  localparam logic [GW-1:0] G0 = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DW-1:0] D0 = DW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DRAIN
  } st_t;

  st_t                   r_st;
  logic                  r_inv;
  logic                  r_busy;
  logic [BW-1:0]         r_beat;
  logic [SW-1:0]         r_sidx;
  logic [GW-1:0]         r_gcnt;
  logic [DW-1:0]         r_dcnt;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  r_iss;
  logic [SW-1:0]         r_stg;
  logic                  r_lb;
  logic                  r_ls;
  logic                  r_cv  [LATENCY];
  logic [SW-1:0]         r_cs  [LATENCY];
  logic                  r_clb [LATENCY];
  logic                  r_cl  [LATENCY];

  logic                  w_abt;
  logic                  w_iss;
  logic                  w_inv;
  logic [BW-1:0]         w_nb;
  logic [SW-1:0]         w_ns;
  logic [SW-1:0]         w_stg;
  logic [SW-1:0]         w_sh;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_lb;
  logic                  w_ls;

  // w_nb/w_ns describe the beat that would be issued at this edge
  always_comb begin
    w_abt = abort & (r_st != S_IDLE);
    w_iss = 1'b0;
    w_nb  = r_beat + BW'(1);
    w_ns  = r_sidx;
    w_inv = r_inv;
    unique case (r_st)
      S_IDLE: begin
        if (start) begin
          w_iss = 1'b1;
          w_nb  = '0;
          w_ns  = '0;
          w_inv = inverse;
        end
      end
      S_RUN: begin
        if (r_beat != LB) begin
          w_iss = 1'b1;
        end else if (r_sidx != LS && GAP_CYCLES == 0) begin
          w_iss = 1'b1;
          w_nb  = '0;
          w_ns  = r_sidx + SW'(1);
        end
      end
      S_GAP: begin
        if (r_gcnt == '0) begin
          w_iss = 1'b1;
          w_nb  = '0;
          w_ns  = r_sidx + SW'(1);
        end
      end
      default: ;
    endcase
    if (w_abt) w_iss = 1'b0;
    w_stg  = w_inv ? LS - w_ns : w_ns;
    w_sh   = LS - w_stg;
    w_addr = ((ADDR_WIDTH'(1) << w_stg) - ADDR_WIDTH'(1))
           + (ADDR_WIDTH'(w_nb) >> w_sh);
    w_lb   = (w_nb == LB);
    w_ls   = w_lb & (w_ns == LS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= S_IDLE;
      r_inv   <= 1'b0;
      r_busy  <= 1'b0;
      r_beat  <= '0;
      r_sidx  <= '0;
      r_gcnt  <= '0;
      r_dcnt  <= '0;
      r_raddr <= '0;
      r_iss   <= 1'b0;
      r_stg   <= '0;
      r_lb    <= 1'b0;
      r_ls    <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        r_cv[i]  <= 1'b0;
        r_cs[i]  <= '0;
        r_clb[i] <= 1'b0;
        r_cl[i]  <= 1'b0;
      end
    end else begin
      if (w_iss) begin
        r_raddr <= w_addr;
        r_beat  <= w_nb;
        r_sidx  <= w_ns;
      end
      r_iss <= w_iss;
      r_stg <= w_iss ? w_stg : '0;
      r_lb  <= w_iss & w_lb;
      r_ls  <= w_iss & w_ls;
      r_cv[0]  <= r_iss & ~w_abt;
      r_cs[0]  <= w_abt ? '0 : r_stg;
      r_clb[0] <= r_lb & ~w_abt;
      r_cl[0]  <= r_ls & ~w_abt;
      for (int i = 1; i < LATENCY; i++) begin
        r_cv[i]  <= r_cv[i-1] & ~w_abt;
        r_cs[i]  <= w_abt ? '0 : r_cs[i-1];
        r_clb[i] <= r_clb[i-1] & ~w_abt;
        r_cl[i]  <= r_cl[i-1] & ~w_abt;
      end
      if (w_abt) begin
        r_st   <= S_IDLE;
        r_busy <= 1'b0;
      end else begin
        unique case (r_st)
          S_IDLE: begin
            if (start) begin
              r_st   <= S_RUN;
              r_busy <= 1'b1;
              r_inv  <= inverse;
            end
          end
          S_RUN: begin
            if (r_beat == LB) begin
              if (r_sidx == LS) begin
                r_st   <= S_DRAIN;
                r_dcnt <= D0;
              end else if (GAP_CYCLES > 0) begin
                r_st   <= S_GAP;
                r_gcnt <= G0;
              end
            end
          end
          S_GAP: begin
            if (r_gcnt == '0) r_st <= S_RUN;
            else r_gcnt <= r_gcnt - GW'(1);
          end
          S_DRAIN: begin
            if (r_dcnt == '0) begin
              r_st   <= S_IDLE;
              r_busy <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt - DW'(1);
            end
          end
          default: r_st <= S_IDLE;
        endcase
      end
    end
  end

  assign raddr        = r_raddr;
  assign tf_valid     = r_cv[LATENCY-1];
  assign tf_stage     = r_cs[LATENCY-1];
  assign tf_last_beat = r_clb[LATENCY-1];
  assign tf_last      = r_cl[LATENCY-1];
  assign busy         = r_busy;
  assign done         = r_cl[LATENCY-1];

endmodule

// File: tb/tb_tf_rd_sched.sv
// Scoreboard bench for tf_rd_sched: default build plus a LATENCY=3, GAP=2 build.
// Expected tags are queued at stimulus time and popped whenever tf_valid is seen.
module tb_tf_rd_sched;

  logic        clk = 1'b0;
  logic        rst_n, start, inverse, abort, start3, abort3;
  logic [10:0] raddr, raddr3;
  logic [1:0]  tf_stage, tf_stage3;
  logic        tf_valid, tf_last_beat, tf_last, busy, done;
  logic        tf_valid3, tf_last_beat3, tf_last3, busy3, done3;

  typedef struct packed {
    logic [10:0] a;
    logic [1:0]  s;
    logic        lb;
    logic        ls;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  tf_rd_sched u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
    .abort(abort), .raddr(raddr), .tf_valid(tf_valid),
    .tf_stage(tf_stage), .tf_last_beat(tf_last_beat),
    .tf_last(tf_last), .busy(busy), .done(done)
  );

  tf_rd_sched #(.LATENCY(3), .GAP_CYCLES(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .inverse(1'b0),
    .abort(abort3), .raddr(raddr3), .tf_valid(tf_valid3),
    .tf_stage(tf_stage3), .tf_last_beat(tf_last_beat3),
    .tf_last(tf_last3), .busy(busy3), .done(done3)
  );

  function automatic exp_t mk(input bit inv, input int i);
    int   fa[12] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 6};
    int   ia[12] = '{3, 4, 5, 6, 1, 1, 2, 2, 0, 0, 0, 0};
    exp_t e;
    e.a  = 11'(inv ? ia[i] : fa[i]);
    e.s  = 2'(inv ? 2 - i / 4 : i / 4);
    e.lb = ((i % 4) == 3);
    e.ls = (i == 11);
    return e;
  endfunction

  task automatic push1(input bit inv, input int n);
    for (int i = 0; i < n; i++) q1.push_back(mk(inv, i));
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic [10:0] h1 = '0;
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (tf_valid) begin
      nvec++;
      g = {h1, tf_stage, tf_last_beat, tf_last};
      if (q1.size() == 0) begin
        nerr++;
        $display("FAIL tagA: unexpected word a=%0d s=%0d", h1, tf_stage);
      end else begin
        e = q1.pop_front();
        if (g != e || done != e.ls) begin
          nerr++;
          $display("FAIL tagA: got a=%0d s=%0d lb=%0d last=%0d done=%0d expected a=%0d s=%0d lb=%0d last=%0d",
                   g.a, g.s, g.lb, g.ls, done, e.a, e.s, e.lb, e.ls);
        end
      end
    end
    h1 = raddr;
  end

  logic [10:0] h3 [3] = '{default: '0};
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (tf_valid3) begin
      nvec++;
      g = {h3[2], tf_stage3, tf_last_beat3, tf_last3};
      if (q3.size() == 0) begin
        nerr++;
        $display("FAIL tagB: unexpected word a=%0d s=%0d", h3[2], tf_stage3);
      end else begin
        e = q3.pop_front();
        if (g != e || done3 != e.ls) begin
          nerr++;
          $display("FAIL tagB: got a=%0d s=%0d lb=%0d last=%0d done=%0d expected a=%0d s=%0d lb=%0d last=%0d",
                   g.a, g.s, g.lb, g.ls, done3, e.a, e.s, e.lb, e.ls);
        end
      end
    end
    h3[2] = h3[1];
    h3[1] = h3[0];
    h3[0] = raddr3;
  end

  // Called at the negedge of cycle 0; start is sampled at the edge ending it.
  task automatic run(input bit inv, input int ncyc,
                     input int s1, input int s2, input int s3,
                     input int abt, input int rsta, input int rstd,
                     input int blo, input int bhi,
                     input int blo2, input int bhi2,
                     input int d1, input int d2);
    start   = 1'b1;
    inverse = inv;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      chk($sformatf("busy c%0d", c), int'(busy),
          int'((c >= blo && c <= bhi) || (c >= blo2 && c <= bhi2)));
      chk($sformatf("done c%0d", c), int'(done),
          int'(c == d1 || c == d2));
      start   = (c == s1 || c == s2 || c == s3);
      inverse = start ? inv : ~inv;
      abort   = (c == abt);
      if (c == rsta) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst raddr", int'(raddr), 0);
        chk("rst valid", int'(tf_valid), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst last", int'(tf_last), 0);
      end
      if (c == rstd) #2 rst_n = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    inverse = 1'b0;
    abort   = 1'b0;
    start3  = 1'b0;
    abort3  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset raddr", int'(raddr), 0);
    chk("reset valid", int'(tf_valid), 0);
    chk("reset stage", int'(tf_stage), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset busy3", int'(busy3), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // forward, no gap, latency 1
    push1(1'b0, 12);
    run(1'b0, 16, -1, -1, -1, -1, -1, -1, 1, 13, 0, -1, 13, -1);
    // inverse order, inverse toggled after start
    push1(1'b1, 12);
    run(1'b1, 16, -1, -1, -1, -1, -1, -1, 1, 13, 0, -1, 13, -1);
    // starts while busy ignored, back-to-back start after done
    push1(1'b0, 12);
    push1(1'b0, 12);
    run(1'b0, 30, 5, 13, 14, -1, -1, -1, 1, 13, 15, 27, 13, 27);
    // abort in cycle 7, then a clean sequence
    push1(1'b0, 6);
    run(1'b0, 20, -1, -1, -1, 7, -1, -1, 1, 7, 0, -1, -1, -1);
    push1(1'b0, 12);
    run(1'b0, 16, -1, -1, -1, -1, -1, -1, 1, 13, 0, -1, 13, -1);
    // reset mid-sequence, then a clean sequence
    push1(1'b0, 5);
    run(1'b0, 12, -1, -1, -1, -1, 6, 8, 1, 6, 0, -1, -1, -1);
    push1(1'b0, 12);
    run(1'b0, 16, -1, -1, -1, -1, -1, -1, 1, 13, 0, -1, 13, -1);

    // latency 3, two gap cycles between stages
    for (int i = 0; i < 12; i++) q3.push_back(mk(1'b0, i));
    start3 = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (c == 5 || c == 6) chk($sformatf("gap raddr c%0d", c), int'(raddr3), 0);
      if (c == 11 || c == 12) chk($sformatf("gap raddr c%0d", c), int'(raddr3), 2);
      if (c == 3) chk("L3 valid c3", int'(tf_valid3), 0);
      if (c == 4) chk("L3 valid c4", int'(tf_valid3), 1);
      if (c == 18) chk("L3 done c18", int'(done3), 0);
      if (c == 19) chk("L3 done c19", int'(done3), 1);
      if (c == 19) chk("L3 busy c19", int'(busy3), 1);
      if (c == 20) chk("L3 busy c20", int'(busy3), 0);
    end

    repeat (3) @(negedge clk);
    chk("queue A left", q1.size(), 0);
    chk("queue B left", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
